// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state type and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam int REG_W = 4;
  localparam int MEM_WAIT_DEF = 4;
  typedef enum logic {IDLE, BUSY} mem_state_e;
endpackage

// File: rtl/mem_wait_seq.sv
// mem_wait_seq: data-memory wait-state sequencer (clk, rst, mem_req -> freeze_mem, mem_ready)
module mem_wait_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = MEM_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic freeze_mem,
  output logic mem_ready
);
  localparam logic [3:0] W_INIT = 4'(MEM_WAIT - 1);
  mem_state_e state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic start;
  always_comb begin
    start = state_q == IDLE && mem_req && MEM_WAIT != 0;
    freeze_mem = start || (state_q == BUSY && wcnt_q != 4'd0);
    mem_ready = MEM_WAIT == 0 ? mem_req : state_q == BUSY && wcnt_q == 4'd0;
    state_d = start ? BUSY : (state_q == BUSY && wcnt_q != 4'd0) ? BUSY : IDLE;
    wcnt_d = start ? W_INIT : wcnt_q != 4'd0 ? wcnt_q - 4'd1 : 4'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      wcnt_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: freeze/flush controller (ID/EX/MEM hazard indices, mem_req, branch_taken -> freezes, flushes, mem_ready, stall/flush counters)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1,
  parameter int MEM_WAIT = MEM_WAIT_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_vld,
  input  logic             id_src2_vld,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_req,
  input  logic             branch_taken,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_back,
  output logic             mem_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic freeze_mem, hazard, e1, e2, m1, m2, do_stall, do_flush;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  mem_wait_seq #(.MEM_WAIT(MEM_WAIT)) u_seq (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .freeze_mem(freeze_mem),
    .mem_ready(mem_ready)
  );
  always_comb begin
    e1 = id_src1_vld && exe_wb_en && exe_dest == id_src1;
    e2 = id_src2_vld && exe_wb_en && exe_dest == id_src2;
    m1 = id_src1_vld && mem_wb_en && mem_dest == id_src1;
    m2 = id_src2_vld && mem_wb_en && mem_dest == id_src2;
    hazard = FWD_EN ? exe_mem_r_en && (e1 || e2) : e1 || e2 || m1 || m2;
    do_flush = !freeze_mem && branch_taken;
    do_stall = !freeze_mem && !branch_taken && hazard;
    freeze_pc = freeze_mem || do_stall;
    freeze_if_id = freeze_mem || do_stall;
    freeze_back = freeze_mem;
    flush_if_id = do_flush;
    flush_id_ex = do_flush || do_stall;
    stall_cnt_d = (do_stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (do_flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule
